switch_led_sequencer: RTL and testbench

//   Board-level controller for the 4-switch / 4-LED demo path. It sits between the raw switch pins and the LEDs.
//   It synchronises and debounces 4 switches plus a mode button, then sequences the LEDs through 4 modes:

---
 rtl/switch_led_sequencer.sv | 173 +++++++++++++++++
 tb/tb_switch_led_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/switch_led_sequencer.sv
// switch_led_sequencer: board-level controller for the 4-switch / 4-LED demo.
//   Synchronises and debounces four switches plus a mode button, then drives
//   the LEDs from one of four modes: LOGIC, CHASE, COUNT and TOGGLE.
//   The mode button steps LOGIC -> CHASE -> COUNT -> TOGGLE -> LOGIC.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable cycles before a new level is accepted (>=1)
//   TICK_CYCLES      prescaler period in clocks for chase/count steps (>=2)
//
// Ports
//   i_clk            system clock, single domain
//   i_rst            asynchronous active-high reset
//   i_switch_1..4    raw switch pins (asynchronous)
//   i_mode_btn       raw mode push-button (asynchronous)
//   o_led_1..4       registered LED drives
//   o_mode           current mode (only when SEQ_MODE_OUT_EN is defined)
//
// Build option
//   SEQ_MODE_OUT_EN  adds the o_mode port; LED/FSM behaviour is unchanged.

// One input lane: 2-flop synchroniser followed by a debounce counter.
module switch_led_sequencer_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            // Any cycle agreeing with the accepted level restarts the run,
            // so only a full run of mismatching cycles flips the level.
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module switch_led_sequencer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TICK_CYCLES     = 12500000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_switch_1,
    input  logic       i_switch_2,
    input  logic       i_switch_3,
    input  logic       i_switch_4,
    input  logic       i_mode_btn,
`ifdef SEQ_MODE_OUT_EN
    output logic [1:0] o_mode,
`endif
    output logic       o_led_1,
    output logic       o_led_2,
    output logic       o_led_3,
    output logic       o_led_4
);
    localparam int NUM_IN = 5;
    localparam int PW     = $clog2(TICK_CYCLES);

    typedef enum logic [1:0] {
        M_LOGIC  = 2'd0,
        M_CHASE  = 2'd1,
        M_COUNT  = 2'd2,
        M_TOGGLE = 2'd3
    } mode_t;

    // Lane order: [4]=mode button, [3:0]=switch 4..1
    logic [NUM_IN-1:0] raw;
    logic [NUM_IN-1:0] db;
    logic [NUM_IN-1:0] db_d;
    logic [NUM_IN-1:0] press;

    assign raw = {i_mode_btn, i_switch_4, i_switch_3, i_switch_2, i_switch_1};

    for (genvar g = 0; g < NUM_IN; g++) begin : g_in
        switch_led_sequencer_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (i_clk),
            .rst  (i_rst),
            .raw  (raw[g]),
            .level(db[g])
        );
    end

    assign press = db & ~db_d;

    logic [3:0] sw;
    logic       mode_press;
    assign sw         = db[3:0];
    assign mode_press = press[4];

    mode_t      mode;
    logic [PW-1:0] presc;
    logic       tick;
    logic [3:0] chase;     // one-hot {led4..led1}
    logic [3:0] count;
    logic [3:0] tog;
    logic [3:0] led_q;     // {led4..led1}

    assign tick = (presc == PW'(TICK_CYCLES - 1));

    // Mode FSM plus the per-mode state it owns. A mode press clears all
    // mode state and takes priority over any tick or switch press that
    // lands in the same cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mode  <= M_LOGIC;
            db_d  <= '0;
            presc <= '0;
            chase <= 4'b0001;
            count <= '0;
            tog   <= '0;
            led_q <= '0;
        end else begin
            db_d <= db;

            if (mode_press) begin
                mode  <= mode_t'(mode + 2'd1);
                presc <= '0;
                chase <= 4'b0001;
                count <= '0;
                tog   <= '0;
            end else begin
                presc <= tick ? '0 : presc + PW'(1);
                if (tick && !sw[1]) begin
                    if (mode == M_CHASE)
                        chase <= sw[0] ? {chase[0], chase[3:1]}   // toward led1
                                       : {chase[2:0], chase[3]};  // toward led4
                    if (mode == M_COUNT)
                        count <= sw[0] ? count - 4'd1 : count + 4'd1;
                end
                if (mode == M_TOGGLE)
                    tog <= tog ^ press[3:0];
            end

            // LEDs follow the current mode's function, one cycle behind.
            case (mode)
                M_LOGIC:  led_q <= {^sw, sw[0] ^ sw[1], sw[0] | sw[1], sw[0] | sw[1]};
                M_CHASE:  led_q <= chase;
                M_COUNT:  led_q <= count;
                default:  led_q <= tog;
            endcase
        end
    end

    assign o_led_1 = led_q[0];
    assign o_led_2 = led_q[1];
    assign o_led_3 = led_q[2];
    assign o_led_4 = led_q[3];

`ifdef SEQ_MODE_OUT_EN
    assign o_mode = mode;
`endif
endmodule

// File: tb/tb_switch_led_sequencer.sv
module tb_switch_led_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0, s4 = 1'b0, btn = 1'b0;
    logic l1, l2, l3, l4;
    logic [3:0] leds;
    logic [1:0] mode_o;

    int n_cmp = 0;
    int n_bad = 0;

    switch_led_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .TICK_CYCLES    (8)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_switch_1(s1),
        .i_switch_2(s2),
        .i_switch_3(s3),
        .i_switch_4(s4),
        .i_mode_btn(btn),
`ifdef SEQ_MODE_OUT_EN
        .o_mode    (mode_o),
`endif
        .o_led_1   (l1),
        .o_led_2   (l2),
        .o_led_3   (l3),
        .o_led_4   (l4)
    );

`ifndef SEQ_MODE_OUT_EN
    assign mode_o = 2'd0;
`endif

    assign leds = {l4, l3, l2, l1};

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sw;    // {s4,s3,s2,s1}
        logic [3:0] exp;   // {led4..led1}
    } vec_t;

    vec_t vecs[7];

    // Drive and sample 1 time unit after the rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_mode(input string name, input logic [1:0] exp);
`ifdef SEQ_MODE_OUT_EN
        check(name, {2'b00, mode_o}, {2'b00, exp});
`endif
    endtask

    task automatic press_mode();
        btn = 1'b1;
        step(8);
        btn = 1'b0;
        step(8);
    endtask

    task automatic glitch(input int hold, input int exp_cnt);
        int c;
        c = 0;
        s3 = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            step(1);
            if (i == hold) s3 = 1'b0;
            c += int'(l4);
        end
        n_cmp++;
        if (c != exp_cnt) begin
            n_bad++;
            $display("FAIL glitch_hold%0d: led4 high %0d cycles, expected %0d", hold, c, exp_cnt);
        end
    endtask

    initial begin
        vecs[0] = '{sw: 4'b0001, exp: 4'b1111};
        vecs[1] = '{sw: 4'b0011, exp: 4'b0011};
        vecs[2] = '{sw: 4'b0100, exp: 4'b1000};
        vecs[3] = '{sw: 4'b1111, exp: 4'b0011};
        vecs[4] = '{sw: 4'b0010, exp: 4'b1111};
        vecs[5] = '{sw: 4'b0111, exp: 4'b1011};
        vecs[6] = '{sw: 4'b0000, exp: 4'b0000};

        // Reset state
        step(3);
        check("in_reset", leds, 4'b0000);
        rst = 1'b0;
        step(20);
        check("after_reset", leds, 4'b0000);
        check_mode("mode_after_reset", 2'd0);

        // Exact latency: change first sampled on edge 1, LED on edge 7
        s1 = 1'b1;
        step(6);
        check("latency_edge6", leds, 4'b0000);
        step(1);
        check("latency_edge7", leds, 4'b1111);

        // LOGIC truth table
        for (int i = 0; i < 7; i++) begin
            {s4, s3, s2, s1} = vecs[i].sw;
            step(12);
            check($sformatf("logic_vec%0d", i), leds, vecs[i].exp);
        end

        // Glitch rejection and acceptance on s3 (drives led4)
        glitch(3, 0);
        glitch(4, 4);
        glitch(6, 6);
        step(4);

        // CHASE
        btn = 1'b1;
        step(8);
        btn = 1'b0;
        check("chase_start", leds, 4'b0001);
        check_mode("mode_chase", 2'd1);
        step(7);
        check("chase_before_tick", leds, 4'b0001);
        step(1);
        check("chase_1", leds, 4'b0010);
        step(8);
        check("chase_2", leds, 4'b0100);
        step(8);
        check("chase_3", leds, 4'b1000);
        step(8);
        check("chase_wrap", leds, 4'b0001);
        s1 = 1'b1;
        step(8);
        check("chase_rev_wrap", leds, 4'b1000);
        step(8);
        check("chase_rev_2", leds, 4'b0100);
        s2 = 1'b1;
        step(16);
        check("chase_freeze_a", leds, 4'b0100);
        step(8);
        check("chase_freeze_b", leds, 4'b0100);
        s1 = 1'b0;
        s2 = 1'b0;
        step(10);

        // COUNT
        btn = 1'b1;
        step(8);
        btn = 1'b0;
        check_mode("mode_count", 2'd2);
        for (int k = 0; k <= 16; k++) begin
            check($sformatf("count_up_%0d", k), leds, 4'(k % 16));
            if (k != 16) step(8);
        end
        s1 = 1'b1;
        step(8);
        check("count_down_15", leds, 4'd15);
        step(8);
        check("count_down_14", leds, 4'd14);

        // Reset mid-COUNT clears LEDs without waiting for a clock edge
        step(3);
        rst = 1'b1;
        s1  = 1'b0;
        #1;
        check("async_reset_leds", leds, 4'b0000);
        check_mode("async_reset_mode", 2'd0);
        step(2);
        rst = 1'b0;
        step(5);

        // Back to TOGGLE
        press_mode();
        press_mode();
        press_mode();
        check("toggle_start", leds, 4'b0000);
        check_mode("mode_toggle", 2'd3);
        s2 = 1'b1;
        step(7);
        check("toggle_s2_pre", leds, 4'b0000);
        step(1);
        check("toggle_s2_on", leds, 4'b0010);
        s2 = 1'b0;
        step(10);
        check("toggle_s2_release", leds, 4'b0010);
        s2 = 1'b1;
        step(8);
        check("toggle_s2_off", leds, 4'b0000);
        s2 = 1'b0;
        step(10);
        s1 = 1'b1;
        s3 = 1'b1;
        step(8);
        check("toggle_s1_s3", leds, 4'b0101);
        s1 = 1'b0;
        s3 = 1'b0;
        step(10);

        // Mode press in the same cycle as an s1 press: mode wins
        btn = 1'b1;
        s1  = 1'b1;
        step(7);
        check("mode_vs_toggle_pre", leds, 4'b0101);
        step(1);
        check("mode_vs_toggle_logic", leds, 4'b1111);
        check_mode("mode_wrap_logic", 2'd0);
        btn = 1'b0;
        s1  = 1'b0;
        step(10);
        check("logic_after_wrap", leds, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
